// File: rtl/skolem_checker.sv
// skolem_checker: walks every universal assignment x = {a, b}, asks the
// Skolem block under test for a witness y, and checks
//   F(a,b,y) = $signed(a | zext(y)) <= $signed(b)
// The run stops at the first counterexample, at a response timeout, or after
// the all-ones assignment. Unrealizable points are counted and never fail.
module skolem_checker #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sk_req_valid,
  output logic [2*W-1:0]    sk_req_x,
  input  logic              sk_rsp_valid,
  input  logic              sk_rsp_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [2*W-1:0]    cex_x,
  output logic              cex_y,
  output logic [2*W:0]      num_checked,
  output logic [2*W:0]      num_unreal
);

  localparam int XW = 2 * W;
  localparam int CW = 2 * W + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x;
  logic          y_q;
  logic [TW-1:0] wcnt;
  logic [W-1:0]  a, b;
  logic          f0, f1, fy;
  logic          unreal, eval_fail, last_pt, wait_expired;

  // Two's-complement check of the benchmark specification; y is zero-extended.
  function automatic logic spec_f(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic yv);
    logic signed [W-1:0] lhs;
    logic signed [W-1:0] rhs;
    lhs = av | {{(W-1){1'b0}}, yv};
    rhs = bv;
    return (lhs <= rhs);
  endfunction

  assign a            = x[XW-1:W];
  assign b            = x[W-1:0];
  assign f0           = spec_f(a, b, 1'b0);
  assign f1           = spec_f(a, b, 1'b1);
  assign fy           = spec_f(a, b, y_q);
  assign unreal       = !f0 && !f1;
  assign eval_fail    = !unreal && !fy;
  assign last_pt      = &x;
  assign wait_expired = (wcnt == TW'(TIMEOUT - 1));

  assign sk_req_valid = (state == ISSUE);
  assign sk_req_x     = x;
  assign busy         = (state == ISSUE) || (state == WAIT) || (state == EVAL);
  assign done         = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: sequencing of request, response wait and evaluation.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT: begin
        if (sk_rsp_valid)      state_nx = EVAL;
        else if (wait_expired) state_nx = DONE;
      end
      EVAL: begin
        if (eval_fail || last_pt) state_nx = DONE;
        else                      state_nx = ISSUE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: point counter, witness capture, wait counter, results and tallies.
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y_q         <= 1'b0;
      wcnt        <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cex_x       <= '0;
      cex_y       <= 1'b0;
      num_checked <= '0;
      num_unreal  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x           <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cex_x       <= '0;
            cex_y       <= 1'b0;
            num_checked <= '0;
            num_unreal  <= '0;
          end
        end
        ISSUE: wcnt <= '0;
        WAIT: begin
          if (sk_rsp_valid) begin
            y_q <= sk_rsp_y;
          end else if (wait_expired) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            cex_x   <= x;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        EVAL: begin
          num_checked <= num_checked + CW'(1);
          if (unreal) num_unreal <= num_unreal + CW'(1);
          if (eval_fail) begin
            pass  <= 1'b0;
            cex_x <= x;
            cex_y <= y_q;
          end else if (last_pt) begin
            pass <= 1'b1;
          end else begin
            x <= x + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_checker.sv
// Directed bench for skolem_checker (W=4, TIMEOUT=15) with a behavioural
// Skolem responder whose witness policy and latency are set per scenario.
module tb_skolem_checker;

  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sk_req_valid;
  logic [7:0] sk_req_x;
  logic       sk_rsp_valid;
  logic       sk_rsp_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [7:0] cex_x;
  logic       cex_y;
  logic [8:0] num_checked;
  logic [8:0] num_unreal;

  int checks;
  int failures;

  // responder control: mode 0 -> y=0, 1 -> y=b[0], 2 -> y=1, 3 -> never answer
  int   rmode;
  int   rlat;
  bit   stray;
  int   pend;
  int   cd;
  logic [7:0] rx;

  skolem_checker #(.W(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sk_req_valid(sk_req_valid), .sk_req_x(sk_req_x),
    .sk_rsp_valid(sk_rsp_valid), .sk_rsp_y(sk_rsp_y),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cex_x(cex_x), .cex_y(cex_y),
    .num_checked(num_checked), .num_unreal(num_unreal)
  );

  always #5 clk = ~clk;

  // Responder: answers L cycles after the ISSUE cycle; optional stray strobes
  initial begin
    sk_rsp_valid = 1'b0;
    sk_rsp_y     = 1'b0;
    pend         = 0;
    cd           = 0;
    rx           = '0;
    forever begin
      @(posedge clk); #1;
      sk_rsp_valid = 1'b0;
      sk_rsp_y     = 1'b0;
      if (!busy) pend = 0;
      if (sk_req_valid) begin
        pend = 1;
        cd   = rlat;
        rx   = sk_req_x;
      end else if (pend != 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          pend = 0;
          if (rmode != 3) begin
            sk_rsp_valid = 1'b1;
            sk_rsp_y     = (rmode == 2) ? 1'b1 : (rmode == 1) ? rx[0] : 1'b0;
          end
        end
      end
      if (stray && (sk_req_valid || !busy)) begin
        sk_rsp_valid = 1'b1;
        sk_rsp_y     = 1'b1;
      end
    end
  end

  // Pulse start for one cycle and follow the run; n counts cycles after the start cycle.
  task automatic do_run(output int done_at, output int req1, output int req2);
    int n;
    done_at = -1;
    req1    = -1;
    req2    = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 3000) begin
      if (sk_req_valid) begin
        if (req1 < 0)      req1 = n;
        else if (req2 < 0) req2 = n;
      end
      if (done) begin
        done_at = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({sk_req_valid, busy, done, pass, timeout, cex_y} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000",
               {sk_req_valid, busy, done, pass, timeout, cex_y});
    end
    checks++;
    if (sk_req_x !== 8'h00 || cex_x !== 8'h00) begin
      failures++;
      $display("FAIL reset_x: got req_x=%h cex_x=%h want 00 00", sk_req_x, cex_x);
    end
    checks++;
    if (num_checked !== 9'd0 || num_unreal !== 9'd0) begin
      failures++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", num_checked, num_unreal);
    end
  endtask

  task automatic test_full_y0;
    int d, r1, r2;
    rmode = 0; rlat = 1;
    do_run(d, r1, r2);
    checks++;
    if (d !== 769) begin failures++; $display("FAIL full_y0 done_cycle: got %0d want 769", d); end
    checks++;
    if (r1 !== 1) begin failures++; $display("FAIL full_y0 first_req: got %0d want 1", r1); end
    checks++;
    if (r2 - r1 !== 3) begin failures++; $display("FAIL full_y0 req_interval: got %0d want 3", r2 - r1); end
    checks++;
    if (pass !== 1'b1 || timeout !== 1'b0) begin
      failures++; $display("FAIL full_y0 pass_timeout: got %b%b want 10", pass, timeout);
    end
    checks++;
    if (num_checked !== 9'd256) begin failures++; $display("FAIL full_y0 num_checked: got %0d want 256", num_checked); end
    checks++;
    if (num_unreal !== 9'd120) begin failures++; $display("FAIL full_y0 num_unreal: got %0d want 120", num_unreal); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      failures++; $display("FAIL full_y0 after_done: got done=%b busy=%b pass=%b want 0 0 1", done, busy, pass);
    end
  endtask

  task automatic test_timeout;
    int d, r1, r2;
    rmode = 3; rlat = 1;
    do_run(d, r1, r2);
    checks++;
    if (d !== 17) begin failures++; $display("FAIL timeout done_cycle: got %0d want 17", d); end
    checks++;
    if (timeout !== 1'b1 || pass !== 1'b0) begin
      failures++; $display("FAIL timeout flags: got timeout=%b pass=%b want 1 0", timeout, pass);
    end
    checks++;
    if (cex_x !== 8'h00 || num_checked !== 9'd0) begin
      failures++; $display("FAIL timeout cex_count: got cex_x=%h checked=%0d want 00 0", cex_x, num_checked);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fail_y1;
    int d, r1, r2;
    rmode = 2; rlat = 1;
    do_run(d, r1, r2);
    checks++;
    if (d !== 4) begin failures++; $display("FAIL fail_y1 done_cycle: got %0d want 4", d); end
    checks++;
    if (pass !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL fail_y1 flags: got pass=%b timeout=%b want 0 0", pass, timeout);
    end
    checks++;
    if (cex_x !== 8'h00 || cex_y !== 1'b1) begin
      failures++; $display("FAIL fail_y1 cex: got x=%h y=%b want 00 1", cex_x, cex_y);
    end
    checks++;
    if (num_checked !== 9'd1 || num_unreal !== 9'd0) begin
      failures++; $display("FAIL fail_y1 counts: got %0d/%0d want 1/0", num_checked, num_unreal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_yb0_lat3;
    int d, r1, r2;
    rmode = 1; rlat = 3;
    do_run(d, r1, r2);
    checks++;
    if (d !== 1281) begin failures++; $display("FAIL yb0 done_cycle: got %0d want 1281", d); end
    checks++;
    if (r2 - r1 !== 5) begin failures++; $display("FAIL yb0 req_interval: got %0d want 5", r2 - r1); end
    checks++;
    if (pass !== 1'b1 || timeout !== 1'b0) begin
      failures++; $display("FAIL yb0 pass_timeout: got %b%b want 10", pass, timeout);
    end
    checks++;
    if (num_checked !== 9'd256 || num_unreal !== 9'd120) begin
      failures++; $display("FAIL yb0 counts: got %0d/%0d want 256/120", num_checked, num_unreal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stray;
    int d, r1, r2;
    rmode = 0; rlat = 1;
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_run(d, r1, r2);
    stray = 1'b0;
    checks++;
    if (d !== 769) begin failures++; $display("FAIL stray done_cycle: got %0d want 769", d); end
    checks++;
    if (pass !== 1'b1 || num_checked !== 9'd256) begin
      failures++; $display("FAIL stray result: got pass=%b checked=%0d want 1 256", pass, num_checked);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun;
    int  n, d, r1, r2;
    bit  found, saw_done, prev_req40;
    rmode = 0; rlat = 1;
    found = 0; saw_done = 0; prev_req40 = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 1000) begin
      if (done) saw_done = 1;
      if (prev_req40 && busy && !sk_req_valid) begin
        found = 1;
        break;
      end
      prev_req40 = sk_req_valid && (sk_req_x == 8'h40);
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!found || saw_done) begin
      failures++; $display("FAIL midrun reach_wait40: got found=%b done_seen=%b want 1 0", found, saw_done);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({sk_req_valid, busy, done, pass, timeout, cex_y} !== 6'b0) begin
      failures++; $display("FAIL midrun reset_flags: got %b want 000000",
                           {sk_req_valid, busy, done, pass, timeout, cex_y});
    end
    checks++;
    if (sk_req_x !== 8'h00 || cex_x !== 8'h00 || num_checked !== 9'd0 || num_unreal !== 9'd0) begin
      failures++; $display("FAIL midrun reset_data: got x=%h cex=%h chk=%0d unr=%0d want 00 00 0 0",
                           sk_req_x, cex_x, num_checked, num_unreal);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrun no_done: got done=%b busy=%b want 0 0", done, busy);
    end
    do_run(d, r1, r2);
    checks++;
    if (d !== 769 || pass !== 1'b1 || num_checked !== 9'd256) begin
      failures++; $display("FAIL midrun rerun: got cyc=%0d pass=%b chk=%0d want 769 1 256", d, pass, num_checked);
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    rmode    = 0;
    rlat     = 1;
    stray    = 1'b0;
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_y0();
    test_timeout();
    test_fail_y1();
    test_yb0_lat3();
    test_stray();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skolem_checker.md
# skolem_checker

Sequential exhaustive checker for single-output Skolem functions of the bvsle-over-bvor benchmark family. It enumerates every universal assignment x = {a, b} and sends each one to a Skolem-function block under test over a request/response handshake. For each response y it evaluates the specification F(a,b,y) = $signed(a | {{W-1{1'b0}},y}) <= $signed(b), counts unrealizable points, and stops at the first counterexample or timeout. It sits beside the combinational Skolem netlists as their consumer: the netlist produces the witness, and this block validates it.

## Interface
- W, default 4: width of each universal vector a and b; x is 2W bits, with a = x[2W-1:W] and b = x[W-1:0].
- TIMEOUT, default 15: maximum cycles spent in WAIT before the run aborts.
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begins a run; sampled only in IDLE.
- sk_req_valid  out  1  one-cycle pulse that presents sk_req_x.
- sk_req_x  out  2W  current universal assignment; held stable from ISSUE through EVAL.
- sk_rsp_valid  in  1  response strobe; sampled only in WAIT.
- sk_rsp_y  in  1  Skolem witness; captured when sk_rsp_valid is high in WAIT.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  result of the last run; held until the next start.
- timeout  out  1  last run aborted on timeout; held until the next start.
- cex_x  out  2W  failing assignment; valid when pass=0.
- cex_y  out  1  failing witness; valid when pass=0 and timeout=0.
- num_checked  out  2W+1  count of points evaluated in EVAL, including a failing one.
- num_unreal  out  2W+1  count of points where neither y=0 nor y=1 satisfies F.

## Operation
- States: IDLE, ISSUE, WAIT, EVAL, DONE.
- IDLE: when start=1, clear x, num_checked, num_unreal, pass, timeout, cex_x and cex_y; then go to ISSUE.
- ISSUE: drive sk_req_valid=1 with sk_req_x=x; clear the wait counter; go to WAIT.
- WAIT: when sk_rsp_valid=1, latch y and go to EVAL.
  - If the wait counter reaches TIMEOUT with no response: set timeout=1, pass=0, cex_x=x; go to DONE.
  - sk_rsp_valid outside WAIT is ignored.
- EVAL:
  - Compute f0=F(a,b,0), f1=F(a,b,1) and fy=F(a,b,y); increment num_checked.
  - If !f0 && !f1: increment num_unreal. The point passes regardless of y.
  - Else if !fy: set pass=0, cex_x=x, cex_y=y; go to DONE.
  - Else if x is all-ones: set pass=1; go to DONE.
  - Else: increment x; go to ISSUE.
- DONE: done=1 for one cycle; go to IDLE.
- Arithmetic: the OR uses y zero-extended to W bits. The comparison is a W-bit two's-complement compare, with no overflow because both operands are W bits. Counters are 2W+1 bits so the full count 2^(2W) fits without wrapping.
- start is ignored while busy=1 and in DONE.

## Timing
- Reset values: state IDLE; sk_req_valid=0, sk_req_x=0, busy=0, done=0, pass=0, timeout=0, cex_x=0, cex_y=0, num_checked=0, num_unreal=0.
- Reset asserted mid-run returns the block to IDLE on the next edge. No done pulse is produced.
- The first sk_req_valid appears one cycle after the start cycle.
- A response with latency L (sk_rsp_valid L cycles after the ISSUE cycle, L>=1) gives 2+L cycles per point.
- The DONE/done pulse occurs in the cycle after the final EVAL or the timeout.
- Timeout fires in the cycle after TIMEOUT consecutive WAIT cycles without a response.

## Test plan
- W=4, responder y=0, L=1: start -> done pulse 769 cycles after the start cycle (256 points × 3 cycles + DONE); pass=1, num_checked=256, num_unreal=120.
- W=4, responder y=b[0], L=3: pass=1, num_checked=256, num_unreal=120, and the request interval is 5 cycles.
- W=4, responder y=1, L=1: fails on the first point; pass=0, cex_x=0x00, cex_y=1, num_checked=1, timeout=0.
- W=4, responder never answers: done pulse after ISSUE + 15 WAIT cycles + 1; timeout=1, pass=0, cex_x=0x00, num_checked=0.
- Stray sk_rsp_valid=1 in IDLE and ISSUE with y=1, then a correct y=0 in WAIT -> the stray responses have no effect; pass=1.
- rst pulsed while x=0x40 in WAIT -> all outputs return to their reset values; a new start then completes a full run with num_checked=256 and pass=1.
